// File: rtl/ram_stream_defs.sv
// ram_stream_defs: shared widths, FSM encoding and buffer depth for ram_stream_reader
package ram_stream_defs;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF = ADDR_W_DEF + 1;
  localparam int FIFO_DEPTH = 2;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;
endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2: 2-entry synchronous FIFO (push/pop/flush/count, head shown combinationally)
module stream_fifo2
  import ram_stream_defs::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] mem [FIFO_DEPTH];
  logic         rd;
  logic         wr;
  logic         pop_ok;
  assign pop_ok = pop && count != 2'd0;
  assign head = mem[rd];
  always_ff @(posedge clock)
    if (reset || flush) begin
      mem <= '{default: '0};
      rd <= 1'b0;
      wr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= ~wr;
      end
      if (pop_ok)
        rd <= ~rd;
      count <= count + {1'b0, push} - {1'b0, pop_ok};
    end
  always_ff @(posedge clock)
    if (!reset && !flush)
      assert (!(push && count == 2'd2));
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: streams a RAM address range as valid/ready bytes; RAM_STREAM_LOOP_EN repeats the range until abort
module ram_stream_reader
  import ram_stream_defs::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  issue_left;
  logic [LEN_W-1:0]  pop_left;
  logic              pending;
  logic [1:0]        count;
  logic              issue;
  logic              pop;
  logic              flush;
`ifdef RAM_STREAM_LOOP_EN
  logic [ADDR_W-1:0] base_r;
  logic [LEN_W-1:0]  len_r;
`endif
  assign ram_address = addr;
  assign out_valid = count != 2'd0;
  assign pop = out_valid && out_ready;
  assign flush = abort && state != IDLE;
  // a pop this cycle frees a slot, which keeps one byte per cycle under steady ready
  assign issue = state == READ && issue_left != '0 && (count + {1'b0, pending} < 2'd2 || pop);
  stream_fifo2 #(.W(DATA_W)) u_fifo (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .push (pending),
    .pop  (pop),
    .din  (ram_data),
    .head (out_data),
    .count(count)
  );
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      issue_left <= '0;
      pop_left <= '0;
      pending <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef RAM_STREAM_LOOP_EN
      base_r <= '0;
      len_r <= '0;
`endif
    end else if (flush) begin
      state <= IDLE;
      issue_left <= '0;
      pop_left <= '0;
      pending <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      pending <= issue;
      done <= 1'b0;
      if (issue) begin
        addr <= addr + ADDR_W'(1);
        issue_left <= issue_left - LEN_W'(1);
      end
      if (pop)
        pop_left <= pop_left - LEN_W'(1);
      case (state)
        IDLE:
          if (start) begin
            addr <= base_addr;
            issue_left <= length;
            pop_left <= length;
            busy <= length != '0;
            done <= length == '0;
            state <= length == '0 ? FINISH : READ;
`ifdef RAM_STREAM_LOOP_EN
            base_r <= base_addr;
            len_r <= length;
`endif
          end
        READ:
          if (issue && issue_left == LEN_W'(1)) begin
`ifdef RAM_STREAM_LOOP_EN
            addr <= base_r;
            issue_left <= len_r;
`else
            state <= DRAIN;
`endif
          end
        DRAIN:
          if (pop && pop_left == LEN_W'(1)) begin
            state <= FINISH;
            busy <= 1'b0;
            done <= 1'b1;
          end
        FINISH:
          state <= IDLE;
        default:
          state <= IDLE;
      endcase
    end
endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side neighbour of the dual-port block RAM (iCE40 HX8K breakout designs).
- Drives one RAM port's address, captures its registered 1-cycle-latency read data, and presents a contiguous address range as a valid/ready byte stream.
- Feeds downstream consumers such as a UART TX or LED driver.
- Absorbs RAM read latency under backpressure with a 2-entry output buffer.

Parameters:
- ADDR_W, 8, RAM address width; the address space wraps modulo 2^ADDR_W.
- DATA_W, 8, RAM and stream data width.
- LEN_W, ADDR_W+1, transfer length width; allows a full-range transfer of 256.

Ports:
- clock  in  1  single system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a transfer; sampled only in IDLE.
- abort  in  1  synchronous cancel of the current transfer.
- base_addr  in  ADDR_W  first address; sampled with start.
- length  in  LEN_W  number of bytes; sampled with start.
- busy  out  1  high from the accepting edge until done or abort.
- done  out  1  one-cycle pulse after the final byte handshake.
- ram_address  out  ADDR_W  to the RAM port address input.
- ram_data  in  DATA_W  from the RAM port data_out; valid one edge after its address.
- out_data  out  DATA_W  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from the consumer.

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - state=IDLE; busy=0, done=0, out_valid=0, out_data=0, ram_address=0.
  - FIFO empty, pending flag cleared, counters 0.
- State machine: IDLE, READ, DRAIN, FINISH.
  - IDLE: start=1 and length!=0 → READ; latch addr=base_addr, issue_left=length, pop_left=length; busy=1 from the same edge.
  - IDLE: start=1 and length=0 → FINISH directly; no reads, no stream output.
  - READ: ram_address=addr combinationally. A read issues in a cycle when issue_left>0 and fifo_count+pending<2.
  - On an issuing edge: pending<=1, addr<=addr+1 (mod 2^ADDR_W, 0xFF wraps to 0x00), issue_left--.
  - pending=1 at an edge: ram_data is written into the FIFO and pending clears, unless a new issue sets it again.
  - READ → DRAIN when issue_left reaches 0.
  - DRAIN → FINISH on the edge where pop_left goes 1→0. A pop is out_valid&&out_ready.
  - FINISH: done=1 for exactly one cycle, busy=0 at the same edge, then → IDLE. start is ignored during FINISH.
- Latency: start sampled at edge E0 → ram_address=base after E0 → RAM data after E1 → out_valid=1 after E2.
- Throughput: with out_ready held high, one byte per cycle sustained, no bubbles.
- Buffer: out_data/out_valid come from the FIFO head.
  - Push and pop on the same edge is legal: count is unchanged.
  - Push into a full FIFO is impossible by the issue rule. An assertion checks it.
- Backpressure: out_valid stays high and out_data stays stable while out_ready=0. No bytes are lost or duplicated.
- abort (non-IDLE, priority over start and all other transitions): next edge → IDLE, FIFO flushed, pending cleared, out_valid=0, busy=0, no done pulse. In IDLE, abort has no effect.
- start while busy is ignored.

Optional Feature:
- Macro: RAM_STREAM_LOOP_EN.
- Defined: when issue_left would reach 0, addr reloads base_addr and issue_left reloads length. The range repeats indefinitely with no bubble at the seam. DRAIN/FINISH are never entered; done never pulses; only abort or reset ends the transfer.
- Undefined: single-pass behaviour as above; the loop logic is not synthesised.

Decomposition:
- Shared package/header ram_stream_defs: ADDR_W/DATA_W/LEN_W defaults, state encodings (IDLE=0, READ=1, DRAIN=2, FINISH=3), FIFO_DEPTH=2.
- One sub-module: stream_fifo2, a 2-entry synchronous FIFO with push/pop/flush/count and the same clock/reset.

Test Plan:
- RAM preloaded mem[i]=i. Start base=0x03, length=4, out_ready=1 → bytes 03,04,05,06 on consecutive cycles; first out_valid 2 edges after start; done pulses once.
- base=0xFE, length=4 → ram_address sequence FE,FF,00,01; data FE,FF,00,01.
- length=4, out_ready toggled 1,0,0,1,0,1… → out_data held stable while stalled; exactly 4 pops in order; fifo_count never exceeds 2.
- length=0 → no ram reads, no out_valid, done pulses 1 cycle later. length=256 from base 0x80 → 256 bytes wrapping through 0x7F.
- Abort after 2 pops of an 8-byte transfer → out_valid=0 and busy=0 next cycle, no done. A new start at base=0x10 then streams cleanly from 0x10.
- Reset asserted mid-DRAIN with out_ready=0 → all outputs 0 after the edge. With RAM_STREAM_LOOP_EN, base=0x00 and length=3 stream 00,01,02,00,01,02… until abort.
